// File: rtl/nios_fprint_spad_dma_pkg.sv
// Shared definitions for the scratchpad DMA loader.
//   - CSR word offsets on the slave port.
//   - Bit positions inside CTRL and STATUS.
//   - Copy-engine FSM state encoding.
package nios_fprint_spad_dma_pkg;

  localparam logic [2:0] CSR_SRC      = 3'd0;
  localparam logic [2:0] CSR_DST      = 3'd1;
  localparam logic [2:0] CSR_LEN      = 3'd2;
  localparam logic [2:0] CSR_CTRL     = 3'd3;
  localparam logic [2:0] CSR_STATUS   = 3'd4;
  localparam logic [2:0] CSR_CHECKSUM = 3'd5;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } dma_state_e;

endpackage

// File: rtl/nios_fprint_spad_dma_checksum.sv
// Running 32-bit wrapping sum of the words written into the scratchpad
// during one copy.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - zero the sum (start of a new copy); wins over add_en
//   add_en      - add add_data this cycle
//   add_data    - word being written to the scratchpad
//   sum         - current accumulated value
module nios_fprint_spad_dma_checksum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        add_en,
  input  logic [31:0] add_data,
  output logic [31:0] sum
);

  logic [31:0] sum_q;
  logic [31:0] sum_d;

  // The final word of a previous copy can be written in the same cycle a
  // new copy is started, so clear has priority.
  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + add_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/nios_fprint_scratchpad_dma_loader.sv
// Scratchpad DMA loader: copies LEN words from main memory (byte address
// SRC) into the scratchpad starting at word index DST, using a burst-free
// pipelined Avalon-MM read master and the scratchpad write port.
//
// Optional feature macro: SCRATCHPAD_DMA_CHECKSUM_EN
//   defined   - CSR offset 5 returns the wrapping sum of words written
//               during the current/last copy.
//   undefined - no checksum logic, offset 5 reads 0.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   csr_address/write/read      - CSR slave control (word offsets 0..7)
//   csr_writedata/readdata      - CSR data; readdata registered, 1-cycle latency
//   m_address/m_read            - read master request (word-aligned byte address)
//   m_waitrequest               - master stall
//   m_readdata/m_readdatavalid  - in-order read responses
//   spad_address/chipselect/write/byteenable/writedata - scratchpad write port
//   irq                         - STATUS.DONE & CTRL.IRQ_EN
module nios_fprint_scratchpad_dma_loader
  import nios_fprint_spad_dma_pkg::*;
#(
  parameter int SPAD_AW         = 12,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         csr_address,
  input  logic               csr_write,
  input  logic               csr_read,
  input  logic [31:0]        csr_writedata,
  output logic [31:0]        csr_readdata,
  output logic [31:0]        m_address,
  output logic               m_read,
  input  logic               m_waitrequest,
  input  logic [31:0]        m_readdata,
  input  logic               m_readdatavalid,
  output logic [SPAD_AW-1:0] spad_address,
  output logic               spad_chipselect,
  output logic               spad_write,
  output logic [3:0]         spad_byteenable,
  output logic [31:0]        spad_writedata,
  output logic               irq
);

  localparam int CW = SPAD_AW + 1;
  localparam logic [CW-1:0]      CNT_ONE    = CW'(1);
  localparam logic [3:0]         MAX_OS     = 4'(MAX_OUTSTANDING);
  localparam logic [SPAD_AW+1:0] SPAD_DEPTH = {2'b01, {SPAD_AW{1'b0}}};

  dma_state_e         state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [SPAD_AW-1:0] dst_q, dst_d;
  logic [CW-1:0]      len_q, len_d;
  logic               irq_en_q, irq_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [31:0]        addr_q, addr_d;
  logic [CW-1:0]      issued_q, issued_d;
  logic [CW-1:0]      resp_cnt_q, resp_cnt_d;
  logic [3:0]         outstanding_q, outstanding_d;
  logic               spad_write_q, spad_write_d;
  logic [SPAD_AW-1:0] spad_address_q, spad_address_d;
  logic [31:0]        spad_writedata_q, spad_writedata_d;
  logic [31:0]        csr_readdata_q, csr_readdata_d;
  logic               irq_q, irq_d;

  logic               go;
  logic               start;
  logic               req;
  logic               accept;
  logic               resp;
  logic [31:0]        checksum_val;

  always_comb begin
    state_d          = state_q;
    src_d            = src_q;
    dst_d            = dst_q;
    len_d            = len_q;
    irq_en_d         = irq_en_q;
    busy_d           = busy_q;
    done_d           = done_q;
    err_d            = err_q;
    addr_d           = addr_q;
    issued_d         = issued_q;
    resp_cnt_d       = resp_cnt_q;
    outstanding_d    = outstanding_q;
    spad_write_d     = 1'b0;
    spad_address_d   = spad_address_q;
    spad_writedata_d = spad_writedata_q;
    csr_readdata_d   = '0;
    go               = 1'b0;
    start            = 1'b0;

    // Master handshake. Responses arriving while idle are leftovers from
    // before a reset and are dropped.
    req    = (state_q == ST_ISSUE) && (outstanding_q < MAX_OS) && (issued_q != len_q);
    accept = req & ~m_waitrequest;
    resp   = m_readdatavalid & (state_q != ST_IDLE);

    // CSR writes; programming registers are frozen while a copy runs.
    if (csr_write) begin
      case (csr_address)
        CSR_SRC:    if (!busy_q) src_d = {csr_writedata[31:2], 2'b00};
        CSR_DST:    if (!busy_q) dst_d = csr_writedata[SPAD_AW-1:0];
        CSR_LEN:    if (!busy_q) len_d = csr_writedata[SPAD_AW:0];
        CSR_CTRL: begin
          irq_en_d = csr_writedata[CTRL_IRQ_EN];
          go       = csr_writedata[CTRL_GO] & ~busy_q;
        end
        CSR_STATUS: begin
          if (csr_writedata[STATUS_DONE]) done_d = 1'b0;
          if (csr_writedata[STATUS_ERR])  err_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // Launch decision. A zero-length copy completes immediately; a copy
    // that would run past the end of the scratchpad is refused outright.
    if (go) begin
      if (len_q == '0) begin
        done_d = 1'b1;
      end else if (({2'b00, dst_q} + {1'b0, len_q}) > SPAD_DEPTH) begin
        err_d = 1'b1;
      end else begin
        start = 1'b1;
      end
    end

    if (start) begin
      state_d       = ST_ISSUE;
      busy_d        = 1'b1;
      done_d        = 1'b0;
      addr_d        = src_q;
      issued_d      = '0;
      resp_cnt_d    = '0;
      outstanding_d = '0;
    end

    if (accept) begin
      addr_d   = addr_q + 32'd4;
      issued_d = issued_q + CNT_ONE;
      if (issued_q + CNT_ONE == len_q) begin
        state_d = ST_DRAIN;
      end
    end

    // Simultaneous accept and response leaves the in-flight count alone.
    case ({accept, resp})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: ;
    endcase

    // Scratchpad never stalls, so each response becomes a write directly.
    if (resp) begin
      spad_write_d     = 1'b1;
      spad_writedata_d = m_readdata;
      spad_address_d   = dst_q + resp_cnt_q[SPAD_AW-1:0];
      resp_cnt_d       = resp_cnt_q + CNT_ONE;
      if (resp_cnt_q + CNT_ONE == len_q) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    if (csr_read) begin
      case (csr_address)
        CSR_SRC:      csr_readdata_d = src_q;
        CSR_DST:      csr_readdata_d = 32'(dst_q);
        CSR_LEN:      csr_readdata_d = 32'(len_q);
        CSR_CTRL:     csr_readdata_d = {30'd0, irq_en_q, 1'b0};
        CSR_STATUS:   csr_readdata_d = {29'd0, err_q, done_q, busy_q};
        CSR_CHECKSUM: csr_readdata_d = checksum_val;
        default:      csr_readdata_d = '0;
      endcase
    end

    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      src_q            <= '0;
      dst_q            <= '0;
      len_q            <= '0;
      irq_en_q         <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      addr_q           <= '0;
      issued_q         <= '0;
      resp_cnt_q       <= '0;
      outstanding_q    <= '0;
      spad_write_q     <= 1'b0;
      spad_address_q   <= '0;
      spad_writedata_q <= '0;
      csr_readdata_q   <= '0;
      irq_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      src_q            <= src_d;
      dst_q            <= dst_d;
      len_q            <= len_d;
      irq_en_q         <= irq_en_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
      addr_q           <= addr_d;
      issued_q         <= issued_d;
      resp_cnt_q       <= resp_cnt_d;
      outstanding_q    <= outstanding_d;
      spad_write_q     <= spad_write_d;
      spad_address_q   <= spad_address_d;
      spad_writedata_q <= spad_writedata_d;
      csr_readdata_q   <= csr_readdata_d;
      irq_q            <= irq_d;
    end
  end

`ifdef SCRATCHPAD_DMA_CHECKSUM_EN
  nios_fprint_spad_dma_checksum u_checksum (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .add_en   (spad_write_q),
    .add_data (spad_writedata_q),
    .sum      (checksum_val)
  );
`else
  assign checksum_val = '0;
`endif

  assign csr_readdata    = csr_readdata_q;
  assign m_address       = addr_q;
  assign m_read          = req;
  assign spad_address    = spad_address_q;
  assign spad_chipselect = spad_write_q;
  assign spad_write      = spad_write_q;
  assign spad_byteenable = 4'hF;
  assign spad_writedata  = spad_writedata_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_nios_fprint_scratchpad_dma_loader.sv
`timescale 1ns/1ps
module tb_nios_fprint_scratchpad_dma_loader;

  localparam logic [2:0] A_SRC = 3'd0, A_DST = 3'd1, A_LEN = 3'd2;
  localparam logic [2:0] A_CTRL = 3'd3, A_STATUS = 3'd4, A_CKSUM = 3'd5;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  csr_address = '0;
  logic        csr_write = 1'b0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic [11:0] spad_address;
  logic        spad_chipselect;
  logic        spad_write;
  logic [3:0]  spad_byteenable;
  logic [31:0] spad_writedata;
  logic        irq;

  always #5 clk = ~clk;

  nios_fprint_scratchpad_dma_loader #(.SPAD_AW(12), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .spad_address(spad_address), .spad_chipselect(spad_chipselect),
    .spad_write(spad_write), .spad_byteenable(spad_byteenable),
    .spad_writedata(spad_writedata), .irq(irq)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int wait_pct = 0;
  int acc_cnt = 0, wr_cnt = 0, inflight = 0, max_inflight = 0;
  int          pend_due[$];
  logic [31:0] pend_addr[$];
  logic [43:0] exp_q[$];
  logic [43:0] mon_exp;
  logic [31:0] cks_tab [4];

  // Main-memory contents: a small fixed table for the checksum window,
  // a hash of the address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h2000 && a < 32'h2010) return cks_tab[(a - 32'h2000) >> 2];
    return (a * 32'h9E3779B1) ^ 32'h0000_5A5A;
  endfunction

  // Slave response driver: one in-order response per cycle once due.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      void'(pend_due.pop_front());
      m_readdata      = mem_word(pend_addr.pop_front());
      m_readdatavalid = 1'b1;
    end else begin
      m_readdata      = '0;
      m_readdatavalid = 1'b0;
    end
    m_waitrequest = (int'($urandom_range(0, 99)) < wait_pct);
  end

  // Bus monitor and scratchpad scoreboard.
  always @(negedge clk) begin
    if (m_read && !m_waitrequest) begin
      pend_due.push_back(cyc + lat);
      pend_addr.push_back(m_address);
      acc_cnt++;
      inflight++;
      if (inflight > max_inflight) max_inflight = inflight;
    end
    if (m_readdatavalid) inflight--;
    if (spad_write) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spad_unexpected got addr=%0d data=%h expected no write", spad_address, spad_writedata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({spad_address, spad_writedata} !== mon_exp || spad_chipselect !== 1'b1 || spad_byteenable !== 4'hF) begin
          failures++;
          $display("FAIL spad_write got addr=%0d data=%h cs=%b be=%h expected addr=%0d data=%h cs=1 be=f",
                   spad_address, spad_writedata, spad_chipselect, spad_byteenable, mon_exp[43:32], mon_exp[31:0]);
        end else begin
          $display("spad write addr=%0d data=%h", spad_address, spad_writedata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    step();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    step();
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic start_copy(input logic [31:0] src, input int dst, input int len, input bit ien);
    csr_wr(A_SRC, src);
    csr_wr(A_DST, 32'(dst));
    csr_wr(A_LEN, 32'(len));
    for (int i = 0; i < len; i++) exp_q.push_back({12'(dst + i), mem_word(src + 32'(4 * i))});
    csr_wr(A_CTRL, {30'd0, ien, 1'b1});
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      csr_rd(A_STATUS, d);
      if (d[0] == 1'b0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout got BUSY=1 after 3000 polls expected BUSY=0", name);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end else begin
      $display("check %s = %h", name, got);
    end
  endtask

  task automatic drain_slave();
    for (int i = 0; i < 200 && (pend_due.size() != 0 || m_readdatavalid); i++) step();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({m_read, spad_write, irq, csr_readdata} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got m_read=%b spad_write=%b irq=%b rd=%h expected all 0",
               m_read, spad_write, irq, csr_readdata);
    end
    reset = 1'b0;
    step();
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), d);
      chk32($sformatf("reset_csr%0d", a), d, 32'd0);
    end
  endtask

  task automatic test_basic_copy();
    logic [31:0] d;
    int a0 = acc_cnt, w0 = wr_cnt;
    lat = 1; wait_pct = 0;
    start_copy(32'h1000, 0, 4, 1'b1);
    wait_idle("basic");
    csr_rd(A_STATUS, d);
    chk32("basic_status", d, 32'h2);
    chk32("basic_irq", {31'd0, irq}, 32'd1);
    chk32("basic_writes", 32'(wr_cnt - w0), 32'd4);
    chk32("basic_reads", 32'(acc_cnt - a0), 32'd4);
    chk32("basic_exp_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    // DONE is still set from the previous copy; a new GO must clear it.
    start_copy(32'h3000, 20, 2, 1'b1);
    csr_rd(A_STATUS, d);
    chk32("b2b_status_busy", d, 32'h1);
    chk32("b2b_irq_low", {31'd0, irq}, 32'd0);
    wait_idle("b2b");
    chk32("b2b_exp_left", 32'(exp_q.size()), 32'd0);
    csr_wr(A_STATUS, 32'h2);
    csr_rd(A_STATUS, d);
    chk32("b2b_done_w1c", d, 32'h0);
    chk32("b2b_irq_cleared", {31'd0, irq}, 32'd0);
  endtask

  task automatic test_stress();
    int w0 = wr_cnt;
    lat = 5; wait_pct = 50;
    max_inflight = inflight;
    start_copy(32'h4000, 100, 16, 1'b0);
    wait_idle("stress");
    checks++;
    if (max_inflight > MAXO) begin
      failures++;
      $display("FAIL stress_outstanding got %0d in flight expected at most %0d", max_inflight, MAXO);
    end
    chk32("stress_writes", 32'(wr_cnt - w0), 32'd16);
    chk32("stress_exp_left", 32'(exp_q.size()), 32'd0);
    csr_wr(A_STATUS, 32'h2);
  endtask

  task automatic test_range_err();
    logic [31:0] d;
    int a0 = acc_cnt, w0 = wr_cnt;
    lat = 1; wait_pct = 0;
    csr_wr(A_SRC, 32'h5000);
    csr_wr(A_DST, 32'd4090);
    csr_wr(A_LEN, 32'd8);
    csr_wr(A_CTRL, 32'h1);
    csr_rd(A_STATUS, d);
    chk32("err_status", d, 32'h4);
    repeat (10) step();
    chk32("err_no_reads", 32'(acc_cnt - a0), 32'd0);
    chk32("err_no_writes", 32'(wr_cnt - w0), 32'd0);
    csr_wr(A_STATUS, 32'h4);
    csr_rd(A_STATUS, d);
    chk32("err_w1c", d, 32'h0);
    // Exactly reaching the end of the scratchpad is legal.
    start_copy(32'h5000, 4088, 8, 1'b0);
    wait_idle("edge_fit");
    csr_rd(A_STATUS, d);
    chk32("edge_fit_status", d, 32'h2);
    chk32("edge_fit_exp_left", 32'(exp_q.size()), 32'd0);
    csr_wr(A_STATUS, 32'h2);
  endtask

  task automatic test_len0_and_busy();
    logic [31:0] d;
    int a0 = acc_cnt, w0;
    csr_wr(A_LEN, 32'd0);
    csr_wr(A_CTRL, 32'h1);
    csr_rd(A_STATUS, d);
    chk32("len0_done", d, 32'h2);
    repeat (4) step();
    chk32("len0_no_reads", 32'(acc_cnt - a0), 32'd0);
    csr_wr(A_STATUS, 32'h2);
    lat = 5; wait_pct = 50;
    w0 = wr_cnt;
    start_copy(32'h6000, 200, 16, 1'b0);
    csr_wr(A_SRC, 32'hDEAD_0000);
    csr_wr(A_LEN, 32'd3);
    csr_wr(A_CTRL, 32'h1);
    csr_rd(A_SRC, d);
    chk32("busy_src_kept", d, 32'h6000);
    csr_rd(A_LEN, d);
    chk32("busy_len_kept", d, 32'd16);
    wait_idle("busy");
    repeat (10) step();
    chk32("busy_writes", 32'(wr_cnt - w0), 32'd16);
    chk32("busy_exp_left", 32'(exp_q.size()), 32'd0);
    csr_wr(A_STATUS, 32'h2);
  endtask

  task automatic test_reset_mid_copy();
    logic [31:0] d;
    int w0 = wr_cnt;
    bit ok = 1'b0;
    lat = 3; wait_pct = 0;
    start_copy(32'h7000, 300, 8, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (wr_cnt - w0 >= 3) begin ok = 1'b1; break; end
      step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midreset_timeout got %0d writes expected 3", wr_cnt - w0);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({m_read, spad_write, spad_chipselect, irq, m_address, spad_address, spad_writedata, csr_readdata} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got m_read=%b wr=%b irq=%b maddr=%h saddr=%h sdata=%h expected all 0",
               m_read, spad_write, irq, m_address, spad_address, spad_writedata);
    end
    exp_q.delete();
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (20) step();
    chk32("midreset_no_late_writes", 32'(wr_cnt - w0), 32'd0);
    csr_rd(A_STATUS, d);
    chk32("midreset_status", d, 32'h0);
    csr_rd(A_SRC, d);
    chk32("midreset_src", d, 32'h0);
    drain_slave();
  endtask

  task automatic test_checksum();
    logic [31:0] d;
    logic [31:0] exp_sum;
    lat = 1; wait_pct = 0;
`ifdef SCRATCHPAD_DMA_CHECKSUM_EN
    exp_sum = 32'h0000_0005;
`else
    exp_sum = 32'h0;
`endif
    start_copy(32'h2000, 10, 4, 1'b0);
    wait_idle("cksum");
    step();
    csr_rd(A_CKSUM, d);
    chk32("checksum", d, exp_sum);
    csr_rd(3'd6, d);
    chk32("unmapped6", d, 32'h0);
    csr_wr(A_STATUS, 32'h2);
  endtask

  initial begin
    cks_tab[0] = 32'h1;
    cks_tab[1] = 32'h2;
    cks_tab[2] = 32'h3;
    cks_tab[3] = 32'hFFFF_FFFF;
    test_reset();
    test_basic_copy();
    test_back_to_back();
    test_stress();
    test_range_err();
    test_len0_and_busy();
    test_reset_mid_copy();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
